// File: rtl/linear_layer_i4xi4_q_start_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : linear_layer_i4xi4_q_start_fifo_pkg
// Description : Shared sizing helpers and constants for the start-token FIFOs
//               of the Linear_Layer_i4xi4_q dataflow region.
// Revision    : 1.0 - initial release
// ============================================================================
package linear_layer_i4xi4_q_start_fifo_pkg;

    // Storage index width for a given token capacity (never narrower than 1).
    function automatic int addr_width_for(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    // Occupancy / capacity width: one extra bit so the value DEPTH fits.
    function automatic int cap_width(input int addr_width);
        return addr_width + 1;
    endfunction

    localparam int c_start_fifo_depth      = 2;
    localparam int c_start_fifo_addr_width = addr_width_for(c_start_fifo_depth);
    localparam int c_start_fifo_cap_width  = cap_width(c_start_fifo_addr_width);

endpackage
`default_nettype wire

// File: rtl/linear_layer_i4xi4_q_start_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : linear_layer_i4xi4_q_start_fifo_if
// Description : HLS-style if_* write/read handshake bundle of a start FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
interface linear_layer_i4xi4_q_start_fifo_if
    import linear_layer_i4xi4_q_start_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1
);
    logic                             if_write_ce;
    logic                             if_write;
    logic [DATA_WIDTH-1:0]            if_din;
    logic                             if_full_n;
    logic                             if_read_ce;
    logic                             if_read;
    logic [DATA_WIDTH-1:0]            if_dout;
    logic                             if_empty_n;
    logic [cap_width(ADDR_WIDTH)-1:0] if_num_data_valid;
    logic [cap_width(ADDR_WIDTH)-1:0] if_fifo_cap;

    // Producer/consumer side: issues requests, observes flags and data.
    modport master (
        output if_write_ce, if_write, if_din, if_read_ce, if_read,
        input  if_full_n, if_dout, if_empty_n, if_num_data_valid, if_fifo_cap
    );

    // FIFO side.
    modport slave (
        input  if_write_ce, if_write, if_din, if_read_ce, if_read,
        output if_full_n, if_dout, if_empty_n, if_num_data_valid, if_fifo_cap
    );
endinterface
`default_nettype wire

// File: rtl/linear_layer_i4xi4_q_start_fifo_srl.sv
`default_nettype none
// ============================================================================
// Module      : linear_layer_i4xi4_q_start_fifo_srl
// Description : SRL-style shift-register token storage. A write shifts every
//               entry up by one and places din in entry 0; read is
//               asynchronous at addr.
// Revision    : 1.0 - initial release
// ============================================================================
module linear_layer_i4xi4_q_start_fifo_srl #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2
) (
    input  wire logic                  clk,
    input  wire logic                  we,
    input  wire logic [ADDR_WIDTH-1:0] addr,
    input  wire logic [DATA_WIDTH-1:0] din,
    output logic      [DATA_WIDTH-1:0] dout
);

    // Contents are intentionally not reset; occupancy is tracked outside.
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Shift the whole array by one slot on each write.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                r_mem[i] <= r_mem[i-1];
            end
        end
    end

    // Asynchronous read; addresses beyond DEPTH-1 (only when empty) return 0.
    always_comb begin
        dout = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (addr == ADDR_WIDTH'(i)) begin
                dout = r_mem[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/linear_layer_i4xi4_q_start_fifo.sv
`default_nettype none
// ============================================================================
// Module      : linear_layer_i4xi4_q_start_fifo
// Description : Start-token FIFO between a producer process and the
//               PE_i4xi4_pack_2x2 process. Tracks occupancy, keeps registered
//               full/empty flags and gates the if_* handshake so each
//               upstream start token launches the PE exactly once.
// Revision    : 1.0 - initial release
// ============================================================================
module linear_layer_i4xi4_q_start_fifo
    import linear_layer_i4xi4_q_start_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 1,
    parameter int DEPTH      = 2,
    parameter int ADDR_WIDTH = addr_width_for(DEPTH)
) (
    input  wire logic                         clk,
    input  wire logic                         reset,
    linear_layer_i4xi4_q_start_fifo_if.slave  fifo
);

    localparam int                   c_cw    = cap_width(ADDR_WIDTH);
    localparam logic [c_cw-1:0]      c_depth = c_cw'(DEPTH);

    logic [c_cw-1:0]       r_count;
    logic                  r_empty_n;
    logic                  r_full_n;
    logic [c_cw-1:0]       w_count_next;
    logic                  w_push;
    logic                  w_pop;
    logic [ADDR_WIDTH-1:0] w_read_addr;

    // Requests are only honoured while the matching flag allows them.
    assign w_push = fifo.if_write & fifo.if_write_ce & r_full_n;
    assign w_pop  = fifo.if_read  & fifo.if_read_ce  & r_empty_n;

    // Oldest token sits at count-1 because each push shifts entries upward.
    assign w_read_addr = r_count[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);

    // Next occupancy: a simultaneous push and pop leaves it unchanged.
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + c_cw'(1);
            2'b01:   w_count_next = r_count - c_cw'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Occupancy and flags, flags registered from the next occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count   <= '0;
            r_empty_n <= 1'b0;
            r_full_n  <= 1'b1;
        end else begin
            r_count   <= w_count_next;
            r_empty_n <= (w_count_next != '0);
            r_full_n  <= (w_count_next != c_depth);
        end
    end

    linear_layer_i4xi4_q_start_fifo_srl #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_srl (
        .clk  (clk),
        .we   (w_push),
        .addr (w_read_addr),
        .din  (fifo.if_din),
        .dout (fifo.if_dout)
    );

    assign fifo.if_full_n         = r_full_n;
    assign fifo.if_empty_n        = r_empty_n;
    assign fifo.if_num_data_valid = r_count;
    assign fifo.if_fifo_cap       = c_depth;

endmodule
`default_nettype wire

// File: tb/tb_linear_layer_i4xi4_q_start_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_linear_layer_i4xi4_q_start_fifo
// Description : Self-checking bench for the start-token FIFO: directed
//               scenarios with literal expectations, then randomized traffic
//               against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_linear_layer_i4xi4_q_start_fifo;

    localparam int DW    = 1;
    localparam int DEPTH = 2;
    localparam int AW    = 1;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;
    bit   model_q[$];

    linear_layer_i4xi4_q_start_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    linear_layer_i4xi4_q_start_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .fifo  (bus)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare every output against the queue model.
    task automatic check_model();
        chk("empty_n", int'(bus.if_empty_n), int'(model_q.size() != 0));
        chk("full_n",  int'(bus.if_full_n),  int'(model_q.size() != DEPTH));
        chk("count",   int'(bus.if_num_data_valid), model_q.size());
        chk("cap",     int'(bus.if_fifo_cap), DEPTH);
        if (model_q.size() != 0) chk("dout", int'(bus.if_dout), int'(model_q[0]));
    endtask

    // One clock: drive at negedge, advance model at posedge, check at next negedge.
    task automatic cycle(input bit rst, input bit wce, input bit wr, input bit din,
                         input bit rce, input bit rd);
        bit push, pop;
        reset           = rst;
        bus.if_write_ce = wce;
        bus.if_write    = wr;
        bus.if_din      = din;
        bus.if_read_ce  = rce;
        bus.if_read     = rd;
        push = wr && wce && (model_q.size() != DEPTH);
        pop  = rd && rce && (model_q.size() != 0);
        @(posedge clk);
        if (rst) begin
            model_q.delete();
        end else begin
            if (pop)  void'(model_q.pop_front());
            if (push) model_q.push_back(din);
        end
        @(negedge clk);
        check_model();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset = 1'b1;
        bus.if_write_ce = 1'b0; bus.if_write = 1'b0; bus.if_din = 1'b0;
        bus.if_read_ce  = 1'b0; bus.if_read  = 1'b0;
        @(negedge clk);

        // Reset and idle; a read request on empty is ignored.
        cycle(1, 0, 0, 0, 0, 0);
        chk("rst_empty_n", int'(bus.if_empty_n), 0);
        chk("rst_full_n",  int'(bus.if_full_n), 1);
        chk("rst_count",   int'(bus.if_num_data_valid), 0);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 1);
        cycle(0, 0, 0, 0, 0, 0);
        chk("idle_count", int'(bus.if_num_data_valid), 0);

        // Fill with 1 then 0; third write ignored.
        cycle(0, 1, 1, 1, 0, 0);
        chk("push1_empty_n", int'(bus.if_empty_n), 1);
        chk("push1_dout",    int'(bus.if_dout), 1);
        cycle(0, 1, 1, 0, 0, 0);
        chk("full_full_n", int'(bus.if_full_n), 0);
        chk("full_count",  int'(bus.if_num_data_valid), 2);
        chk("full_dout",   int'(bus.if_dout), 1);
        cycle(0, 1, 1, 1, 0, 0);
        chk("ovf_count", int'(bus.if_num_data_valid), 2);

        // Drain: next token is 0, then empty.
        cycle(0, 0, 0, 0, 1, 1);
        chk("pop1_dout",   int'(bus.if_dout), 0);
        chk("pop1_full_n", int'(bus.if_full_n), 1);
        chk("pop1_count",  int'(bus.if_num_data_valid), 1);
        cycle(0, 0, 0, 0, 1, 1);
        chk("pop2_empty_n", int'(bus.if_empty_n), 0);

        // count=1 holding 1, simultaneous push(0)/pop.
        cycle(0, 1, 1, 1, 0, 0);
        cycle(0, 1, 1, 0, 1, 1);
        chk("pp_count", int'(bus.if_num_data_valid), 1);
        chk("pp_dout",  int'(bus.if_dout), 0);
        chk("pp_empty_n", int'(bus.if_empty_n), 1);
        chk("pp_full_n",  int'(bus.if_full_n), 1);

        // Full (0,1) with push(1)/pop: only pop, remaining token is 1.
        cycle(0, 1, 1, 1, 0, 0);
        cycle(0, 1, 1, 1, 1, 1);
        chk("fpp_count", int'(bus.if_num_data_valid), 1);
        chk("fpp_dout",  int'(bus.if_dout), 1);
        // Empty with push(1)/pop: only push.
        cycle(0, 0, 0, 0, 1, 1);
        cycle(0, 1, 1, 1, 1, 1);
        chk("epp_count", int'(bus.if_num_data_valid), 1);
        chk("epp_dout",  int'(bus.if_dout), 1);

        // Reset mid-operation overrides push/pop; write_ce gating.
        cycle(0, 1, 1, 0, 0, 0);
        chk("pre_rst_count", int'(bus.if_num_data_valid), 2);
        cycle(1, 1, 1, 1, 1, 1);
        chk("mid_rst_count",   int'(bus.if_num_data_valid), 0);
        chk("mid_rst_empty_n", int'(bus.if_empty_n), 0);
        chk("mid_rst_full_n",  int'(bus.if_full_n), 1);
        cycle(0, 0, 1, 1, 0, 0);
        chk("nce_count", int'(bus.if_num_data_valid), 0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
                  ($urandom_range(0, 3) != 0), $urandom_range(0, 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
